// File: rtl/sd_crc16_check.sv
// Receive-side CRC16-CCITT checker for SD SPI data blocks (bit-serial, one bit per clock).
// Optional saturating error counter on err_count when SD_CRC16_ERRCNT_EN is defined.
module sd_crc16_check #(
    parameter int BLOCK_LEN = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic [15:0] crc_calc
`ifdef SD_CRC16_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam int CW = $clog2(BLOCK_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SHIFT,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      rx_crc_hi;
    logic [15:0]     crc;
    logic            crc_inv;
    logic [15:0]     crc_step;
    logic            last_bit;
    logic            last_byte;

    assign crc_inv   = shreg[7] ^ crc[15];
    assign crc_step  = {crc[14:0], 1'b0} ^ (crc_inv ? 16'h1021 : 16'h0000);
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == CW'(BLOCK_LEN - 1));

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign crc_calc = crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // start overrides whatever the per-state logic decided
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        case (state)
            IDLE: ;
            WAIT_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (last_bit)
                    state_next = last_byte ? WAIT_HI : WAIT_DATA;
            end
            WAIT_HI: begin
                byte_ready = 1'b1;
                if (byte_valid)
                    state_next = WAIT_LO;
            end
            WAIT_LO: begin
                byte_ready = 1'b1;
                if (byte_valid)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start)
            state_next = WAIT_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            rx_crc_hi <= 8'h00;
            crc       <= 16'h0000;
            crc_ok    <= 1'b0;
        end else if (start) begin
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            rx_crc_hi <= 8'h00;
            crc       <= 16'h0000;
            crc_ok    <= 1'b0;
        end else begin
            case (state)
                WAIT_DATA: begin
                    if (byte_valid) begin
                        shreg   <= byte_in;
                        bit_cnt <= 3'd0;
                    end
                end
                SHIFT: begin
                    crc     <= crc_step;
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit)
                        byte_cnt <= byte_cnt + CW'(1);
                end
                WAIT_HI: begin
                    if (byte_valid)
                        rx_crc_hi <= byte_in;
                end
                WAIT_LO: begin
                    if (byte_valid)
                        crc_ok <= ({rx_crc_hi, byte_in} == crc);
                end
                default: ;
            endcase
        end
    end

`ifdef SD_CRC16_ERRCNT_EN
    // Survives start so software can read an accumulated error total
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= 8'h00;
        else if (done && !crc_ok && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_sd_crc16_check.sv
// Directed self-checking bench for sd_crc16_check: a 512-byte instance and a 9-byte instance.
// Error-counter checks are compiled in only when SD_CRC16_ERRCNT_EN is defined.
module tb_sd_crc16_check;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        start_a = 1'b0, valid_a = 1'b0;
    logic        start_b = 1'b0, valid_b = 1'b0;
    logic        ready_a, busy_a, done_a, ok_a;
    logic        ready_b, busy_b, done_b, ok_b;
    logic [15:0] crc_a, crc_b;
`ifdef SD_CRC16_ERRCNT_EN
    logic [7:0]  err_a, err_b;
`endif

    int errors = 0;
    int checks = 0;
    int timeouts = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    sd_crc16_check #(.BLOCK_LEN(512)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .byte_in(byte_in), .byte_valid(valid_a),
        .byte_ready(ready_a), .busy(busy_a), .done(done_a), .crc_ok(ok_a), .crc_calc(crc_a)
`ifdef SD_CRC16_ERRCNT_EN
        , .err_count(err_a)
`endif
    );

    sd_crc16_check #(.BLOCK_LEN(9)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .byte_in(byte_in), .byte_valid(valid_b),
        .byte_ready(ready_b), .busy(busy_b), .done(done_b), .crc_ok(ok_b), .crc_calc(crc_b)
`ifdef SD_CRC16_ERRCNT_EN
        , .err_count(err_b)
`endif
    );

    always @(posedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? ready_a : ready_b;
    endfunction

    task automatic set_valid(input int s, input logic v);
        if (s == 0) valid_a = v;
        else        valid_b = v;
    endtask

    task automatic do_start(input int s);
        if (s == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Waits (bounded) for byte_ready, then presents the byte for exactly one edge
    task automatic send_byte(input int s, input logic [7:0] b);
        int waited = 0;
        if (timeouts >= 4) return;
        while (!rdy(s) && waited < 40) begin
            tick();
            waited++;
        end
        if (!rdy(s)) begin
            timeouts++;
            errors++;
            checks++;
            $display("[TB] FAIL send_timeout: byte_ready=0 after %0d cycles, required 1", waited);
        end else begin
            byte_in = b;
            set_valid(s, 1'b1);
            tick();
            set_valid(s, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({ready_a, busy_a, done_a, ok_a, crc_a} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdy=%b busy=%b done=%b ok=%b crc=%h, required all 0",
                     ready_a, busy_a, done_a, ok_a, crc_a);
        end
`ifdef SD_CRC16_ERRCNT_EN
        checks++;
        if (err_a !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_err_count: got %0d, required 0", err_a);
        end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy=%b rdy=%b, required 0 0", busy_a, ready_a);
        end
        do_start(0);
        checks++;
        if (busy_a !== 1'b1 || ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_response: busy=%b rdy=%b, required 1 1", busy_a, ready_a);
        end
    endtask

    task automatic test_zeros();
        int d0;
        do_start(0);
        for (int i = 0; i < 512; i++) send_byte(0, 8'h00);
        d0 = done_cnt_a;
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        checks++;
        if (done_a !== 1'b1 || ok_a !== 1'b1 || crc_a !== 16'h0000 || busy_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zeros_done: done=%b ok=%b crc=%h busy=%b, required 1 1 0000 1",
                     done_a, ok_a, crc_a, busy_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || done_cnt_a - d0 != 1) begin
            errors++;
            $display("[TB] FAIL zeros_pulse: done=%b busy=%b pulses=%0d, required 0 0 1",
                     done_a, busy_a, done_cnt_a - d0);
        end
    endtask

    task automatic test_ones();
        int lowcnt;
        int first_gap = 0;
        int bad_gaps = 0;
        do_start(0);
        for (int i = 0; i < 512; i++) begin
            send_byte(0, 8'hFF);
            lowcnt = 0;
            while (!ready_a && lowcnt < 20) begin
                lowcnt++;
                tick();
            end
            if (i == 0) first_gap = lowcnt;
            if (lowcnt != 8) bad_gaps++;
        end
        checks++;
        if (first_gap != 8) begin
            errors++;
            $display("[TB] FAIL first_gap: byte_ready low %0d cycles, required 8", first_gap);
        end
        checks++;
        if (bad_gaps != 0) begin
            errors++;
            $display("[TB] FAIL all_gaps: %0d bytes with gap != 8, required 0", bad_gaps);
        end
        send_byte(0, 8'h7F);
        send_byte(0, 8'hA1);
        checks++;
        if (done_a !== 1'b1 || ok_a !== 1'b1 || crc_a !== 16'h7FA1) begin
            errors++;
            $display("[TB] FAIL ones_good: done=%b ok=%b crc=%h, required 1 1 7fa1", done_a, ok_a, crc_a);
        end
        tick();
    endtask

    task automatic test_bad_crc();
        do_start(0);
        for (int i = 0; i < 512; i++) send_byte(0, 8'hFF);
        send_byte(0, 8'h7F);
        send_byte(0, 8'hA0);
        checks++;
        if (done_a !== 1'b1 || ok_a !== 1'b0 || crc_a !== 16'h7FA1) begin
            errors++;
            $display("[TB] FAIL ones_bad: done=%b ok=%b crc=%h, required 1 0 7fa1", done_a, ok_a, crc_a);
        end
`ifdef SD_CRC16_ERRCNT_EN
        checks++;
        if (err_a !== 8'd0) begin
            errors++;
            $display("[TB] FAIL err_before: got %0d, required 0", err_a);
        end
`endif
        tick();
        checks++;
        if (ok_a !== 1'b0 || crc_a !== 16'h7FA1) begin
            errors++;
            $display("[TB] FAIL bad_hold: ok=%b crc=%h, required 0 7fa1", ok_a, crc_a);
        end
`ifdef SD_CRC16_ERRCNT_EN
        checks++;
        if (err_a !== 8'd1) begin
            errors++;
            $display("[TB] FAIL err_after: got %0d, required 1", err_a);
        end
`endif
    endtask

    task automatic test_string();
        logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        byte_in = 8'h31;
        start_b = 1'b1;
        valid_b = 1'b1;
        tick();
        start_b = 1'b0;
        valid_b = 1'b0;
        checks++;
        if (ready_b !== 1'b1 || crc_b !== 16'h0000 || busy_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_with_valid: rdy=%b crc=%h busy=%b, required 1 0000 1",
                     ready_b, crc_b, busy_b);
        end
        for (int i = 0; i < 9; i++) send_byte(1, msg[i]);
        send_byte(1, 8'h31);
        send_byte(1, 8'hC3);
        checks++;
        if (done_b !== 1'b1 || ok_b !== 1'b1 || crc_b !== 16'h31C3) begin
            errors++;
            $display("[TB] FAIL check_string: done=%b ok=%b crc=%h, required 1 1 31c3", done_b, ok_b, crc_b);
        end
        tick();
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt_a;
        do_start(0);
        for (int i = 0; i < 100; i++) send_byte(0, 8'h55);
        do_start(0);
        checks++;
        if (crc_a !== 16'h0000 || ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_clear: crc=%h rdy=%b, required 0000 1", crc_a, ready_a);
        end
        for (int i = 0; i < 512; i++) begin
            send_byte(0, 8'hFF);
            if (i % 7 == 0) begin
                byte_in = 8'h00;
                valid_a = 1'b1;
                tick();
                valid_a = 1'b0;
            end
        end
        send_byte(0, 8'h7F);
        send_byte(0, 8'hA1);
        checks++;
        if (done_a !== 1'b1 || ok_a !== 1'b1 || crc_a !== 16'h7FA1) begin
            errors++;
            $display("[TB] FAIL abort_then_good: done=%b ok=%b crc=%h, required 1 1 7fa1", done_a, ok_a, crc_a);
        end
        tick();
        checks++;
        if (done_cnt_a - d0 != 1) begin
            errors++;
            $display("[TB] FAIL abort_pulses: %0d done pulses, required 1", done_cnt_a - d0);
        end
    endtask

`ifdef SD_CRC16_ERRCNT_EN
    task automatic test_err_saturate();
        logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int blk = 0; blk < 256; blk++) begin
            do_start(1);
            for (int i = 0; i < 9; i++) send_byte(1, msg[i]);
            send_byte(1, 8'h31);
            send_byte(1, 8'hC2);
            tick();
            if (blk == 0) begin
                checks++;
                if (err_b !== 8'd1) begin
                    errors++;
                    $display("[TB] FAIL err_first: got %0d, required 1", err_b);
                end
            end
        end
        checks++;
        if (err_b !== 8'd255) begin
            errors++;
            $display("[TB] FAIL err_saturate: got %0d, required 255", err_b);
        end
        do_start(1);
        checks++;
        if (err_b !== 8'd255) begin
            errors++;
            $display("[TB] FAIL err_start_keeps: got %0d, required 255", err_b);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int d0;
        int bad = 0;
        do_start(0);
        for (int i = 0; i < 37; i++) send_byte(0, 8'hA5);
        tick();
        tick();
        d0 = done_cnt_a;
        rst = 1'b1;
        #2;
        checks++;
        if ({ready_a, busy_a, done_a, ok_a, crc_a} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_async: rdy=%b busy=%b done=%b ok=%b crc=%h, required all 0",
                     ready_a, busy_a, done_a, ok_a, crc_a);
        end
`ifdef SD_CRC16_ERRCNT_EN
        checks++;
        if (err_a !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_err_clear: got %0d, required 0", err_a);
        end
`endif
        tick();
        rst = 1'b0;
        valid_a = 1'b1;
        byte_in = 8'h11;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        valid_a = 1'b0;
        checks++;
        if (bad != 0 || done_cnt_a != d0) begin
            errors++;
            $display("[TB] FAIL reset_stays_idle: %0d active cycles, %0d done pulses, required 0 0",
                     bad, done_cnt_a - d0);
        end
        do_start(0);
        checks++;
        if (ready_a !== 1'b1 || crc_a !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL restart_after_reset: rdy=%b crc=%h, required 1 0000", ready_a, crc_a);
        end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_ones();
        test_bad_crc();
        test_string();
        test_abort();
`ifdef SD_CRC16_ERRCNT_EN
        test_err_saturate();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
